// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle RV64 sequencing controller (Moore FSM + retired counter)
// Shares one memory port and one ALU across the fetch/decode/execute/memory/write-back steps.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_src,
  output logic             ir_write,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             trap,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_TRAP     = 4'd10
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef struct packed {
    logic       pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       trap;
  } ctrl_t;

  function automatic ctrl_t decode(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:    begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; end
      S_DECODE:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; end
      S_MEM_ADDR: begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b10; end
      S_MEM_RD:   begin c.mem_read = 1'b1; c.iord = 1'b1; end
      S_MEM_WB:   begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      S_MEM_WR:   begin c.mem_write = 1'b1; c.iord = 1'b1; end
      S_EXEC_R:   begin c.alu_src_a = 2'b10; c.alu_op = 2'b10; end
      S_EXEC_I:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b10; c.alu_op = 2'b10; end
      S_ALU_WB:   c.reg_write = 1'b1;
      S_BRANCH:   begin c.alu_src_a = 2'b10; c.alu_op = 2'b01; c.pc_src = 1'b1; end
      S_TRAP:     c.trap = 1'b1;
      default:    c = '0;
    endcase
    return c;
  endfunction

  state_e           state_q, state_d;
  ctrl_t            ctrl_q;
  logic [CNT_W-1:0] retired_q;
  logic             retire;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR: state_d = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:   state_d = S_FETCH;
      S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
      S_EXEC_R:   state_d = S_ALU_WB;
      S_EXEC_I:   state_d = S_ALU_WB;
      S_ALU_WB:   state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
  end

  assign retire = (state_q == S_MEM_WB) || (state_q == S_ALU_WB) || (state_q == S_BRANCH) ||
                  ((state_q == S_MEM_WR) && mem_ready);

  // Output register tracks decode(next state), so it always equals decode(state_q).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      ctrl_q    <= decode(S_FETCH);
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode(state_d);
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Handshake-qualified strobes are masked by reset so nothing writes while it is held.
  assign ir_write   = !reset && (state_q == S_FETCH) && mem_ready;
  assign pc_write   = !reset && (((state_q == S_FETCH) && mem_ready) || ((state_q == S_BRANCH) && zero));
  assign pc_src     = ctrl_q.pc_src;
  assign iord       = ctrl_q.iord;
  assign mem_read   = ctrl_q.mem_read;
  assign mem_write  = ctrl_q.mem_write;
  assign reg_write  = ctrl_q.reg_write;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign alu_src_a  = ctrl_q.alu_src_a;
  assign alu_src_b  = ctrl_q.alu_src_b;
  assign alu_op     = ctrl_q.alu_op;
  assign trap       = ctrl_q.trap;
  assign retired    = retired_q;
  assign state      = state_q;

endmodule
